// File: rtl/prog_loader.sv
// Instruction RAM loader: each debounced key strobe writes the switch word to the
// next sequential address while the processor is held in reset.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              LoadMode,
  input  logic              Strobe,
  input  logic              Rewind,
  input  logic [DATA_W-1:0] SwData,
  output logic              MemWrEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic              CpuHold,
  output logic [DATA_W-1:0] LastWord,
  output logic [ADDR_W:0]   WordCount,
  output logic              Full
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_FULL} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W:0]     word_count;
  logic [ADDR_W:0]     count_inc;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   last_word;
  logic                full;
  logic                cpu_hold;
  logic                at_depth;

  assign count_inc = word_count + (ADDR_W+1)'(1);
  assign at_depth  = (count_inc == DEPTH_CNT);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        // A full buffer re-entered without a rewind stays in FULL so the pointer cannot run on
        if (LoadMode) state_next = (full && !Rewind) ? S_FULL : S_LOAD;
      end
      S_LOAD: begin
        if (!LoadMode)    state_next = S_IDLE;
        else if (Rewind)  state_next = S_LOAD;
        else if (Strobe)  state_next = S_WRITE;
      end
      S_WRITE: begin
        if (Rewind)         state_next = LoadMode ? S_LOAD : S_IDLE;
        else if (!LoadMode) state_next = S_IDLE;
        else if (at_depth)  state_next = S_FULL;
        else                state_next = S_LOAD;
      end
      S_FULL: begin
        if (Rewind)         state_next = LoadMode ? S_LOAD : S_IDLE;
        else if (!LoadMode) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr        <= '0;
      word_count <= '0;
      wr_data    <= '0;
      last_word  <= '0;
      full       <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      cpu_hold <= (state != S_IDLE);
      if (state == S_LOAD && LoadMode && Strobe && !Rewind)
        wr_data <= SwData;
      if (state == S_WRITE) begin
        last_word  <= wr_data;
        word_count <= count_inc;
        // Pointer saturates on the final word; Full marks the end instead
        if (at_depth) full <= 1'b1;
        else          ptr  <= ptr + ADDR_W'(1);
      end
      // Rewind overrides any increment made by a completing write
      if (Rewind) begin
        ptr        <= '0;
        word_count <= '0;
        full       <= 1'b0;
      end
    end
  end

  assign MemWrEn   = (state == S_WRITE);
  assign MemAddr   = ptr;
  assign MemWrData = wr_data;
  assign CpuHold   = cpu_hold;
  assign LastWord  = last_word;
  assign WordCount = word_count;
  assign Full      = full;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued at stimulus time
// and matched against MemAddr/MemWrData whenever MemWrEn is seen.
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              LoadMode;
  logic              Strobe;
  logic              Rewind;
  logic [DATA_W-1:0] SwData;
  logic              MemWrEn;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWrData;
  logic              CpuHold;
  logic [DATA_W-1:0] LastWord;
  logic [ADDR_W:0]   WordCount;
  logic              Full;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [ADDR_W+DATA_W-1:0] sb[$];
  logic [ADDR_W-1:0]        exp_ptr = '0;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .LoadMode(LoadMode), .Strobe(Strobe),
    .Rewind(Rewind), .SwData(SwData), .MemWrEn(MemWrEn), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .CpuHold(CpuHold), .LastWord(LastWord),
    .WordCount(WordCount), .Full(Full)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (Reset === 1'b1 && MemWrEn === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wr_unexpected", 32'(MemWrEn), 32'd0);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = sb.pop_front();
        chk("wr_addr", 32'(MemAddr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
        chk("wr_data", 32'(MemWrData), 32'(e[DATA_W-1:0]));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wren"},  32'(MemWrEn),   32'd0);
    chk({tag, "_addr"},  32'(MemAddr),   32'd0);
    chk({tag, "_data"},  32'(MemWrData), 32'd0);
    chk({tag, "_hold"},  32'(CpuHold),   32'd0);
    chk({tag, "_last"},  32'(LastWord),  32'd0);
    chk({tag, "_count"}, 32'(WordCount), 32'd0);
    chk({tag, "_full"},  32'(Full),      32'd0);
  endtask

  task automatic do_strobe(input logic [DATA_W-1:0] d, input bit exp_wr);
    @(posedge Clock); #1;
    Strobe = 1'b1;
    SwData = d;
    if (exp_wr) begin
      sb.push_back({exp_ptr, d});
      exp_ptr = exp_ptr + 1'b1;
    end
    @(posedge Clock); #1;
    Strobe = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task automatic do_rewind();
    @(posedge Clock); #1;
    Rewind = 1'b1;
    @(posedge Clock); #1;
    Rewind = 1'b0;
    exp_ptr = '0;
    repeat (2) @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b0; LoadMode = 1'b0; Strobe = 1'b0; Rewind = 1'b0; SwData = '0;
    repeat (2) @(negedge Clock);
    chk_reset_vals("rst");
    @(posedge Clock); #1;
    Reset = 1'b1;

    // Single word: one-cycle write, then LastWord/WordCount
    LoadMode = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("t1_hold", 32'(CpuHold), 32'd1);
    @(posedge Clock); #1;
    Strobe = 1'b1; SwData = 16'h1234;
    sb.push_back({exp_ptr, 16'h1234}); exp_ptr = exp_ptr + 1'b1;
    @(posedge Clock); #1;
    Strobe = 1'b0;
    @(negedge Clock);
    chk("t1_wren_hi", 32'(MemWrEn), 32'd1);
    chk("t1_last_pre", 32'(LastWord), 32'd0);
    @(posedge Clock);
    @(negedge Clock);
    chk("t1_wren_lo", 32'(MemWrEn), 32'd0);
    chk("t1_last", 32'(LastWord), 32'h1234);
    chk("t1_count", 32'(WordCount), 32'd1);

    // Three sequential words at 0..2, processor held throughout
    do_rewind();
    for (int i = 0; i < 3; i++) begin
      do_strobe(16'hA001 + 16'(i), 1'b1);
      chk("t2_hold", 32'(CpuHold), 32'd1);
    end
    chk("t2_count", 32'(WordCount), 32'd3);
    chk("t2_last", 32'(LastWord), 32'hA003);
    @(posedge Clock); #1;
    LoadMode = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    chk("t2_hold_lag", 32'(CpuHold), 32'd1);
    @(posedge Clock);
    @(negedge Clock);
    chk("t2_hold_off", 32'(CpuHold), 32'd0);

    // Fill to DEPTH, extra strobe ignored, rewind restarts at 0
    @(posedge Clock); #1;
    LoadMode = 1'b1;
    repeat (2) @(posedge Clock); #1;
    do_rewind();
    for (int i = 0; i < 5; i++) do_strobe(16'hC000 + 16'(i), i < 4);
    chk("t3_full", 32'(Full), 32'd1);
    chk("t3_count", 32'(WordCount), 32'd4);
    chk("t3_addr", 32'(MemAddr), 32'd3);
    chk("t3_last", 32'(LastWord), 32'hC003);
    do_rewind();
    chk("t3_full_clr", 32'(Full), 32'd0);
    chk("t3_count_clr", 32'(WordCount), 32'd0);
    do_strobe(16'hC0DE, 1'b1);
    chk("t3_count_re", 32'(WordCount), 32'd1);

    // Strobe with Rewind: rewind wins, no write
    @(posedge Clock); #1;
    Strobe = 1'b1; Rewind = 1'b1; SwData = 16'hDEAD;
    @(posedge Clock); #1;
    Strobe = 1'b0; Rewind = 1'b0;
    exp_ptr = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("t4_addr", 32'(MemAddr), 32'd0);
    chk("t4_count", 32'(WordCount), 32'd0);
    chk("t4_data", 32'(MemWrData), 32'hC0DE);
    // Second strobe lands while WRITE is active and must be dropped
    @(posedge Clock); #1;
    Strobe = 1'b1; SwData = 16'h1111;
    sb.push_back({exp_ptr, 16'h1111}); exp_ptr = exp_ptr + 1'b1;
    @(posedge Clock); #1;
    SwData = 16'h2222;
    @(posedge Clock); #1;
    Strobe = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("t4_count_drop", 32'(WordCount), 32'd1);
    chk("t4_last_drop", 32'(LastWord), 32'h1111);
    chk("t4_addr_drop", 32'(MemAddr), 32'd1);

    // Asynchronous reset in the middle of a write
    @(posedge Clock); #1;
    Strobe = 1'b1; SwData = 16'hBEEF;
    @(posedge Clock); #2;
    Strobe = 1'b0;
    chk("t5_wren_pre", 32'(MemWrEn), 32'd1);
    Reset = 1'b0;
    LoadMode = 1'b0;
    #1;
    chk_reset_vals("t5_rst");
    @(posedge Clock); #1;
    Reset = 1'b1;
    do_strobe(16'h5555, 1'b0);
    chk("t5_idle_count", 32'(WordCount), 32'd0);
    chk("t5_idle_hold", 32'(CpuHold), 32'd0);

    repeat (2) @(posedge Clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
